// File: rtl/pe_pkg.sv
// Shared constants and index type for the 4-to-2 priority encoder.
package pe_pkg;

   localparam int N_IN  = 4;
   localparam int IDX_W = $clog2(N_IN);

   typedef logic [IDX_W-1:0] idx_t;

endpackage : pe_pkg

// File: rtl/priority_encoder_4x2_if.sv
// Request/index bus between a flag source and the registered priority encoder.
// No backpressure: the source may present a new D every cycle and the encoder
// always accepts it; Y/valid are the registered result of the previous edge.
interface priority_encoder_4x2_if;
   import pe_pkg::*;

   logic [N_IN-1:0] D;
   idx_t            Y;
   logic            valid;

   // Source side drives requests and observes the encoded result.
   modport master (
      output D,
      input  Y,
      input  valid
   );

   // Encoder side.
   modport slave (
      input  D,
      output Y,
      output valid
   );

endinterface : priority_encoder_4x2_if

// File: rtl/priority_encoder_4x2_core.sv
// Purely combinational priority function: index of highest set bit plus any-set flag.
module priority_encoder_4x2_core
   import pe_pkg::*;
(
   input  logic [N_IN-1:0] i_d,
   output idx_t            o_idx,
   output logic            o_any
);

   // D[3] has highest priority; all-zero input encodes as index 0 with o_any low.
   always_comb begin
      o_idx = 2'b00;
      if (i_d[3]) begin
         o_idx = 2'b11;
      end else if (i_d[2]) begin
         o_idx = 2'b10;
      end else if (i_d[1]) begin
         o_idx = 2'b01;
      end else begin
         o_idx = 2'b00;
      end
   end

   assign o_any = |i_d;

endmodule : priority_encoder_4x2_core

// File: rtl/priority_encoder_4x2.sv
// 4-to-2 priority encoder with a one-cycle registered index and valid flag.
module priority_encoder_4x2
   import pe_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   priority_encoder_4x2_if.slave  bus
);

   idx_t w_idx;
   logic w_any;
   idx_t r_y;
   logic r_valid;

   priority_encoder_4x2_core u_core (
      .i_d   (bus.D),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Async clear discards any pending sample; release takes effect on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= 2'b00;
         r_valid <= 1'b0;
      end else begin
         r_y     <= w_idx;
         r_valid <= w_any;
      end
   end

   assign bus.Y     = r_y;
   assign bus.valid = r_valid;

endmodule : priority_encoder_4x2

// File: tb/tb_priority_encoder_4x2.sv
// Self-checking bench for priority_encoder_4x2: reference model plus directed literal checks.
module tb_priority_encoder_4x2;
   import pe_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   priority_encoder_4x2_if bus_if ();

   priority_encoder_4x2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   // Result packed as {valid, Y}: scan from the top bit down for the first set bit.
   function automatic logic [2:0] model(input logic [3:0] d);
      for (int i = 3; i >= 0; i--) begin
         if (d[i]) return {1'b1, i[1:0]};
      end
      return 3'b000;
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got valid=%b Y=%b, expected valid=%b Y=%b at %0t",
                  name, act[2], act[1:0], exp[2], exp[1:0], $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [2:0] exp_q[$];
   logic [2:0] cur_exp = 3'b000;

   always @(negedge rst_n) begin
      exp_q.delete();
      cur_exp = 3'b000;
   end

   always @(posedge clk) begin
      if (rst_n) exp_q.push_back(model(bus_if.D));
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         cur_exp = 3'b000;
      end else if (exp_q.size() > 0) begin
         cur_exp = exp_q.pop_front();
      end
      check("model_cmp", {bus_if.valid, bus_if.Y}, cur_exp);
   end

   // ---------------- driver ----------------
   // Drive D mid-cycle, then check the result just after the following edge.
   task automatic apply_check(input logic [3:0] d, input logic [2:0] exp, input string name);
      @(posedge clk);
      #2 bus_if.D = d;
      @(posedge clk);
      #1 check(name, {bus_if.valid, bus_if.Y}, exp);
   endtask

   initial begin
      bus_if.D = 4'b0000;

      // Reset asserted asynchronously with a live request present.
      #1 rst_n = 1'b0;
      bus_if.D = 4'b1000;
      #1 check("reset_immediate", {bus_if.valid, bus_if.Y}, 3'b000);
      repeat (2) @(posedge clk);
      #1 check("reset_hold", {bus_if.valid, bus_if.Y}, 3'b000);
      #1 rst_n = 1'b1;
      #1 check("reset_release_no_edge", {bus_if.valid, bus_if.Y}, 3'b000);
      @(posedge clk);
      #1 check("first_after_reset", {bus_if.valid, bus_if.Y}, 3'b111);

      // One-hot sweep.
      apply_check(4'b0001, 3'b100, "onehot_0001");
      apply_check(4'b0010, 3'b101, "onehot_0010");
      apply_check(4'b0100, 3'b110, "onehot_0100");
      apply_check(4'b1000, 3'b111, "onehot_1000");

      // Multiple active bits.
      apply_check(4'b1100, 3'b111, "multi_1100");
      apply_check(4'b0110, 3'b110, "multi_0110");
      apply_check(4'b1111, 3'b111, "multi_1111");
      apply_check(4'b0011, 3'b101, "multi_0011");

      // Zero versus bit 0 only.
      apply_check(4'b0000, 3'b000, "zero_input");
      apply_check(4'b0001, 3'b100, "bit0_only");

      // Latency: a mid-cycle change must not show until the next edge.
      @(posedge clk);
      #2 bus_if.D = 4'b0100;
      #1 check("latency_hold", {bus_if.valid, bus_if.Y}, 3'b100);
      @(posedge clk);
      #1 check("latency_update", {bus_if.valid, bus_if.Y}, 3'b110);

      // Exhaustive back-to-back; scoreboard does the checking.
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #2 bus_if.D = c[3:0];
      end

      // Randomised stream.
      for (int r = 0; r < 300; r++) begin
         @(posedge clk);
         #2 bus_if.D = 4'($urandom_range(0, 15));
      end

      // Mid-operation reset discards the pending sample.
      @(posedge clk);
      #2 bus_if.D = 4'b1010;
      @(posedge clk);
      #1 check("pre_midreset", {bus_if.valid, bus_if.Y}, 3'b111);
      #1 rst_n = 1'b0;
      #1 check("midreset_immediate", {bus_if.valid, bus_if.Y}, 3'b000);
      @(posedge clk);
      #1 check("midreset_hold", {bus_if.valid, bus_if.Y}, 3'b000);
      #1 rst_n = 1'b1;
      bus_if.D = 4'b0010;
      @(posedge clk);
      #1 check("after_midreset", {bus_if.valid, bus_if.Y}, 3'b101);

      for (int r = 0; r < 40; r++) begin
         @(posedge clk);
         #2 bus_if.D = 4'($urandom_range(0, 15));
      end

      repeat (3) @(posedge clk);
      #7;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_priority_encoder_4x2
